// File: rtl/burst_adaptor_pkg.sv
// burst_adaptor_pkg: shared widths and FSM state type for the cacheline-to-burst adaptor
package burst_adaptor_pkg;
    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int ADDR_W  = 32;
    localparam int BEATS   = LINE_W / BURST_W;
    localparam int CNT_W   = $clog2(BEATS);
    localparam int OFF_W   = $clog2(LINE_W / 8);
    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;
endpackage

// File: rtl/burst_line_reg.sv
// burst_line_reg: cacheline register with whole-line load and per-beat slice write
module burst_line_reg
    import burst_adaptor_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [LINE_W-1:0]  line,
    input  logic               slice_we,
    input  logic [CNT_W-1:0]   idx,
    input  logic [BURST_W-1:0] slice,
    output logic [LINE_W-1:0]  q
);
    // Whole-line load takes priority over a slice write
    always_ff @(posedge clk) begin
        if (!rst) q <= '0;
        else if (load) q <= line;
        else if (slice_we) q[idx*BURST_W +: BURST_W] <= slice;
    end
endmodule

// File: rtl/burst_adaptor.sv
// burst_adaptor: splits/assembles 256-bit cacheline transfers into 4 ascending 64-bit memory beats
module burst_adaptor
    import burst_adaptor_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               line_read_i,
    input  logic               line_write_i,
    input  logic [ADDR_W-1:0]  line_addr_i,
    input  logic [LINE_W-1:0]  line_wdata_i,
    output logic [LINE_W-1:0]  line_rdata_o,
    output logic               line_resp_o,
    input  logic [BURST_W-1:0] burst_rdata_i,
    input  logic               burst_resp_i,
    output logic               burst_read_o,
    output logic               burst_write_o,
    output logic [BURST_W-1:0] burst_wdata_o,
    output logic [ADDR_W-1:0]  burst_addr_o
);
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [LINE_W-1:0]  wr_line;
    logic               last;
    assign last = cnt == CNT_W'(BEATS - 1);
    // Write staging: captures the upstream line on accept so upstream may change it afterwards
    burst_line_reg u_wr_line (
        .clk      (clk),
        .rst      (rst),
        .load     (state == IDLE && line_write_i),
        .line     (line_wdata_i),
        .slice_we (1'b0),
        .idx      (cnt),
        .slice    ('0),
        .q        (wr_line)
    );
    // Read assembly: separate instance so the last read line survives intervening writes
    burst_line_reg u_rd_line (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b0),
        .line     ('0),
        .slice_we (state == RD_BURST && burst_resp_i),
        .idx      (cnt),
        .slice    (burst_rdata_i),
        .q        (line_rdata_o)
    );
    assign burst_wdata_o = burst_write_o ? wr_line[cnt*BURST_W +: BURST_W] : '0;
    // Transfer FSM with beat counter, line-aligned address latch and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            burst_read_o  <= 1'b0;
            burst_write_o <= 1'b0;
            line_resp_o   <= 1'b0;
            burst_addr_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_write_i || line_read_i) begin
                        burst_addr_o  <= {line_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        burst_write_o <= line_write_i;
                        burst_read_o  <= !line_write_i;
                        state         <= line_write_i ? WR_BURST : RD_BURST;
                    end
                end
                RD_BURST, WR_BURST: begin
                    if (burst_resp_i) begin
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            burst_read_o  <= 1'b0;
                            burst_write_o <= 1'b0;
                            line_resp_o   <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                DONE: begin
                    line_resp_o <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_burst_adaptor.sv
// tb_burst_adaptor: directed scoreboard bench for the cacheline-to-burst adaptor
module tb_burst_adaptor;
    import burst_adaptor_pkg::*;
    logic               clk = 0;
    logic               rst = 0;
    logic               line_read_i = 0;
    logic               line_write_i = 0;
    logic [ADDR_W-1:0]  line_addr_i = '0;
    logic [LINE_W-1:0]  line_wdata_i = '0;
    logic [LINE_W-1:0]  line_rdata_o;
    logic               line_resp_o;
    logic [BURST_W-1:0] burst_rdata_i = '0;
    logic               burst_resp_i = 0;
    logic               burst_read_o;
    logic               burst_write_o;
    logic [BURST_W-1:0] burst_wdata_o;
    logic [ADDR_W-1:0]  burst_addr_o;
    int checks = 0;
    int errors = 0;
    int resp_pulses = 0;
    int exp_resps = 0;
    int proto_hits = 0;
    logic both_d = 0;
    logic [LINE_W-1:0]  line_q[$];
    logic [BURST_W-1:0] beat_q[$];
    always #5 clk = ~clk;
    burst_adaptor dut (
        .clk           (clk),
        .rst           (rst),
        .line_read_i   (line_read_i),
        .line_write_i  (line_write_i),
        .line_addr_i   (line_addr_i),
        .line_wdata_i  (line_wdata_i),
        .line_rdata_o  (line_rdata_o),
        .line_resp_o   (line_resp_o),
        .burst_rdata_i (burst_rdata_i),
        .burst_resp_i  (burst_resp_i),
        .burst_read_o  (burst_read_o),
        .burst_write_o (burst_write_o),
        .burst_wdata_o (burst_wdata_o),
        .burst_addr_o  (burst_addr_o)
    );
    // Count completion pulses, sampled away from the active edge
    always @(negedge clk) if (line_resp_o) resp_pulses++;
    // Protocol monitor: simultaneous read and write requests are flagged once per episode
    always @(posedge clk) begin
        if (line_read_i && line_write_i && !both_d) proto_hits++;
        both_d <= line_read_i && line_write_i;
    end
    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic chk_idle_outputs(input string tag, input logic [LINE_W-1:0] rdata);
        chk({tag, "_resp"}, line_resp_o, 0);
        chk({tag, "_read"}, burst_read_o, 0);
        chk({tag, "_write"}, burst_write_o, 0);
        chk({tag, "_rdata"}, line_rdata_o, rdata);
    endtask
    task automatic wait_req();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (burst_read_o || burst_write_o) return;
        end
        chk("req_timeout", {burst_read_o, burst_write_o}, 2'b11);
    endtask
    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] line, input int gap, input bit stray);
        line_q.push_back(line);
        line_read_i = 1;
        line_addr_i = a;
        wait_req();
        line_addr_i = ~a;
        chk("rd_addr", burst_addr_o, {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}});
        chk("rd_no_write", burst_write_o, 0);
        for (int b = 0; b < BEATS; b++) begin
            repeat (gap) begin
                @(negedge clk);
                chk("rd_gap_read", burst_read_o, 1);
                chk("rd_gap_resp", line_resp_o, 0);
            end
            burst_rdata_i = line[b*BURST_W +: BURST_W];
            burst_resp_i = 1;
            @(negedge clk);
            burst_resp_i = 0;
        end
        exp_resps++;
        if (stray) begin
            burst_resp_i = 1;
            burst_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
        end
        chk("rd_resp", line_resp_o, 1);
        chk("rd_read_drop", burst_read_o, 0);
        chk("rd_data", line_rdata_o, line_q.pop_front());
        line_read_i = 0;
        @(negedge clk);
        chk_idle_outputs("rd_after", line);
        if (stray) begin
            burst_rdata_i = 64'h5A5A_5A5A_5A5A_5A5A;
            @(negedge clk);
            chk_idle_outputs("rd_stray_idle", line);
            burst_resp_i = 0;
            burst_rdata_i = '0;
        end
    endtask
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] line, input int gap, input bit both);
        for (int b = 0; b < BEATS; b++) beat_q.push_back(line[b*BURST_W +: BURST_W]);
        line_write_i = 1;
        line_read_i = both;
        line_wdata_i = line;
        line_addr_i = a;
        wait_req();
        line_wdata_i = ~line;
        line_addr_i = ~a;
        chk("wr_addr", burst_addr_o, {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}});
        chk("wr_no_read", burst_read_o, 0);
        for (int b = 0; b < BEATS; b++) begin
            repeat (gap) begin
                @(negedge clk);
                chk("wr_gap_write", burst_write_o, 1);
            end
            chk("wr_write", burst_write_o, 1);
            chk("wr_beat", burst_wdata_o, beat_q.pop_front());
            burst_resp_i = 1;
            @(negedge clk);
            burst_resp_i = 0;
        end
        exp_resps++;
        chk("wr_resp", line_resp_o, 1);
        chk("wr_write_drop", burst_write_o, 0);
        line_write_i = 0;
        line_read_i = 0;
        @(negedge clk);
        chk("wr_pulse", line_resp_o, 0);
        chk("wr_idle_write", burst_write_o, 0);
    endtask
    initial begin
        logic [LINE_W-1:0] l_rd;
        logic [LINE_W-1:0] l_wr;
        logic [LINE_W-1:0] l_b2b;
        l_rd  = {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}, {16{4'h0}}};
        l_wr  = {4{64'hDEAD_0123_4567_BEEF}} ^ {64'h3, 64'h2, 64'h1, 64'h0};
        l_b2b = {64'hA3A3_0000_1111_2222, 64'hB2B2_3333_4444_5555, 64'hC1C1_6666_7777_8888, 64'hD0D0_9999_AAAA_BBBB};
        repeat (3) @(negedge clk);
        chk("rst_addr", burst_addr_o, 0);
        chk("rst_wdata", burst_wdata_o, 0);
        chk_idle_outputs("rst", '0);
        rst = 1;
        @(negedge clk);
        do_read(32'h1234_567F, l_rd, 0, 0);
        line_write_i = 1;
        line_wdata_i = l_wr;
        line_addr_i = 32'h0000_1040;
        wait_req();
        repeat (2) begin
            burst_resp_i = 1;
            @(negedge clk);
        end
        burst_resp_i = 0;
        rst = 0;
        line_write_i = 0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_addr", burst_addr_o, 0);
            chk("mid_rst_wdata", burst_wdata_o, 0);
            chk_idle_outputs("mid_rst", '0);
        end
        rst = 1;
        repeat (2) begin
            @(negedge clk);
            chk_idle_outputs("post_rst", '0);
        end
        do_write(32'h8000_00A4, l_wr, 2, 0);
        do_read(32'h0000_0020, ~l_rd, 1, 1);
        do_read(32'h0000_0040, l_b2b, 0, 0);
        do_write(32'hCAFE_F00D, l_b2b, 0, 0);
        do_read(32'h7777_7777, l_wr, 0, 0);
        do_write(32'h0000_0100, ~l_b2b, 1, 1);
        chk("proto_both_flagged", proto_hits, 1);
        chk("line_held_after_write", line_rdata_o, l_wr);
        repeat (3) @(negedge clk);
        chk("resp_pulse_count", resp_pulses, exp_resps);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
